change_dispenser: RTL and testbench

//  Pays change out of the vending machine: the outbound coin path, the reverse of the money-in path.

---
 rtl/change_dispenser.sv | 181 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount out of a three-denomination coin hopper,
// greedy largest-coin-first, with per-coin inventory, refill and a sticky hopper-timeout fault.
module change_dispenser #(
    parameter int AMT_W      = 8,
    parameter int CNT_W      = 6,
    parameter int VAL_HI     = 5,
    parameter int VAL_MID    = 2,
    parameter int VAL_LO     = 1,
    parameter int INIT_COUNT = 0,
    parameter int TIMEOUT    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [2:0]       eject,
    input  logic             eject_ack,
    input  logic             refill_valid,
    input  logic [1:0]       refill_sel,
    input  logic [CNT_W-1:0] refill_count,
    input  logic             fault_clear,
    output logic             done,
    output logic [AMT_W-1:0] paid,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic             fault,
    output logic [CNT_W-1:0] count_hi,
    output logic [CNT_W-1:0] count_mid,
    output logic [CNT_W-1:0] count_lo
);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE, FAULT} state_t;

    localparam int               TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [1:0]       sel, sel_nx;          // coin index: 0=LO, 1=MID, 2=HI
    logic [TMR_W-1:0] timer;
    logic             accept, take, finish, finish_short;
    logic             timer_clr, timer_inc, go_fault;
    logic [CNT_W-1:0] cnt [3];

    function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] d);
        case (d)
            2'd2:    coin_val = AMT_W'(VAL_HI);
            2'd1:    coin_val = AMT_W'(VAL_MID);
            default: coin_val = AMT_W'(VAL_LO);
        endcase
    endfunction

    // Refill and ack-decrement are combined before saturating, so a full
    // counter that loses one coin and gains one stays full.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                    input logic [CNT_W-1:0] add,
                                                    input logic             dec);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
        next_count = (sum > {1'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_W-1:0];
    endfunction

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        sel_nx       = sel;
        accept       = 1'b0;
        take         = 1'b0;
        finish       = 1'b0;
        finish_short = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        go_fault     = 1'b0;
        eject        = 3'b000;
        req_ready    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_amount == '0) begin
                        state_nx = DONE;
                        finish   = 1'b1;
                    end else begin
                        state_nx = SELECT;
                    end
                end
            end
            SELECT: begin
                timer_clr = 1'b1;
                if (remaining == '0) begin
                    state_nx = DONE;
                    finish   = 1'b1;
                end else if (remaining >= coin_val(2'd2) && cnt[2] != '0) begin
                    sel_nx   = 2'd2;
                    state_nx = EJECT;
                end else if (remaining >= coin_val(2'd1) && cnt[1] != '0) begin
                    sel_nx   = 2'd1;
                    state_nx = EJECT;
                end else if (remaining >= coin_val(2'd0) && cnt[0] != '0) begin
                    sel_nx   = 2'd0;
                    state_nx = EJECT;
                end else begin
                    state_nx     = DONE;
                    finish       = 1'b1;
                    finish_short = 1'b1;
                end
            end
            EJECT: begin
                eject     = 3'b001 << sel;
                timer_inc = 1'b1;
                state_nx  = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Timer counts cycles since the eject; an ack on the last cycle still wins.
                if (eject_ack) begin
                    take     = 1'b1;
                    state_nx = SELECT;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    go_fault     = 1'b1;
                    finish       = 1'b1;
                    finish_short = 1'b1;
                    state_nx     = FAULT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            FAULT:   if (fault_clear) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
            timer <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
        end
    end

    // NOTE: the inventory is only three counters, so it is reset like ordinary registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            paid      <= '0;
            done      <= 1'b0;
            short     <= 1'b0;
            fault     <= 1'b0;
            for (int i = 0; i < 3; i++) cnt[i] <= CNT_W'(INIT_COUNT);
        end else begin
            done <= finish;
            if (finish) short <= finish_short;
            if (accept) begin
                remaining <= req_amount;
                paid      <= '0;
            end else if (take) begin
                remaining <= remaining - coin_val(sel);
                paid      <= paid + coin_val(sel);
            end
            if (go_fault)                          fault <= 1'b1;
            else if (state == FAULT && fault_clear) fault <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= next_count(cnt[i],
                                     (refill_valid && refill_sel == 2'(i)) ? refill_count : '0,
                                     take && sel == 2'(i));
            end
        end
    end

    assign count_lo  = cnt[0];
    assign count_mid = cnt[1];
    assign count_hi  = cnt[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table vectors, hand-written corner
// sequences, and randomized requests against a greedy-payout reference model.
module tb_change_dispenser;

    localparam int AMT_W = 8;
    localparam int CNT_W = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic [2:0]       eject;
    logic             eject_ack;
    logic             refill_valid;
    logic [1:0]       refill_sel;
    logic [CNT_W-1:0] refill_count;
    logic             fault_clear;
    logic             done;
    logic [AMT_W-1:0] paid;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic             fault;
    logic [CNT_W-1:0] count_hi, count_mid, count_lo;

    change_dispenser dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .eject(eject), .eject_ack(eject_ack),
        .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_count(refill_count),
        .fault_clear(fault_clear),
        .done(done), .paid(paid), .short(short), .remaining(remaining), .fault(fault),
        .count_hi(count_hi), .count_mid(count_mid), .count_lo(count_lo)
    );

    always #5 clock = ~clock;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic refill(input int sel, input int count);
        refill_valid = 1'b1;
        refill_sel   = 2'(sel);
        refill_count = CNT_W'(count);
        tick();
        refill_valid = 1'b0;
        refill_count = '0;
    endtask

    // Results of the most recent serve() call.
    logic [2:0]       got_coins[$];
    int               got_done, got_paid, got_short, got_rem;

    task automatic serve(input int amt, input int max_d);
        int d;
        got_coins.delete();
        got_done  = 0;
        got_paid  = 0;
        got_short = 0;
        got_rem   = 0;
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        tick();
        req_valid  = 1'b0;
        req_amount = '0;
        for (int cyc = 0; cyc < 600 && got_done == 0; cyc++) begin
            if (done) begin
                got_done  = 1;
                got_paid  = int'(paid);
                got_short = int'(short);
                got_rem   = int'(remaining);
            end else if (eject != 3'b000) begin
                got_coins.push_back(eject);
                tick();
                check("eject_one_cycle", int'(eject), 0);
                d = int'($urandom_range(max_d, 0));
                repeat (d) tick();
                eject_ack = 1'b1;
                tick();
                eject_ack = 1'b0;
            end else begin
                tick();
            end
        end
        check("done_seen", got_done, 1);
        tick();
    endtask

    // Reference model: greedy payout over an inventory array.
    int         coin_val[3] = '{1, 2, 5};
    int         m_inv[3];
    int         m_paid, m_short, m_rem;
    logic [2:0] exp_coins[$];

    task automatic model_request(input int amt);
        int pick;
        exp_coins.delete();
        m_rem  = amt;
        m_paid = 0;
        while (m_rem > 0) begin
            pick = -1;
            for (int d = 2; d >= 0; d--) begin
                if (pick < 0 && coin_val[d] <= m_rem && m_inv[d] > 0) pick = d;
            end
            if (pick < 0) break;
            exp_coins.push_back(3'b001 << pick);
            m_inv[pick] -= 1;
            m_rem       -= coin_val[pick];
            m_paid      += coin_val[pick];
        end
        m_short = (m_rem != 0) ? 1 : 0;
    endtask

    typedef struct {
        int         hi, mid, lo, amt;
        int         e_paid, e_short, e_rem;
        int         e_hi, e_mid, e_lo;
        int         e_n;
        logic [11:0] e_seq;   // coin i in bits [3*i +: 3]
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, k, amt, s, c;
        logic [2:0] exp_coin;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_amount   = '0;
        eject_ack    = 1'b0;
        refill_valid = 1'b0;
        refill_sel   = 2'd0;
        refill_count = '0;
        fault_clear  = 1'b0;

        vecs[0] = '{10, 10, 10, 8, 8, 0, 0, 9, 9, 9, 3, 12'b000_001_010_100};
        vecs[1] = '{ 0,  0,  2, 5, 2, 1, 3, 0, 0, 0, 2, 12'b000_000_001_001};
        vecs[2] = '{ 1,  0,  0, 7, 5, 1, 2, 0, 0, 0, 1, 12'b000_000_000_100};
        vecs[3] = '{ 0,  3,  0, 5, 4, 1, 1, 0, 1, 0, 2, 12'b000_000_010_010};
        vecs[4] = '{ 2,  2,  2,12,12, 0, 0, 0, 1, 2, 3, 12'b000_010_100_100};
        vecs[5] = '{ 0,  0,  0, 3, 0, 1, 3, 0, 0, 0, 0, 12'b000_000_000_000};
        vecs[6] = '{ 1,  1,  1, 9, 8, 1, 1, 0, 0, 0, 3, 12'b000_001_010_100};
        vecs[7] = '{ 3,  0,  5, 4, 4, 0, 0, 3, 0, 1, 4, 12'b001_001_001_001};

        // Reset state
        #2;
        check("rst_async_ready", int'(req_ready), 1);
        apply_reset();
        check("rst_ready", int'(req_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_paid", int'(paid), 0);
        check("rst_short", int'(short), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_eject", int'(eject), 0);
        check("rst_counts", int'(count_hi) + int'(count_mid) + int'(count_lo), 0);

        // Table-driven requests
        foreach (vecs[v]) begin
            apply_reset();
            refill(2, vecs[v].hi);
            refill(1, vecs[v].mid);
            refill(0, vecs[v].lo);
            serve(vecs[v].amt, 2);
            check($sformatf("v%0d_ncoins", v), got_coins.size(), vecs[v].e_n);
            for (int i = 0; i < vecs[v].e_n && i < got_coins.size(); i++) begin
                exp_coin = vecs[v].e_seq[3*i +: 3];
                check($sformatf("v%0d_coin%0d", v, i), int'(got_coins[i]), int'(exp_coin));
            end
            check($sformatf("v%0d_paid", v), got_paid, vecs[v].e_paid);
            check($sformatf("v%0d_short", v), got_short, vecs[v].e_short);
            check($sformatf("v%0d_remaining", v), got_rem, vecs[v].e_rem);
            check($sformatf("v%0d_hi", v), int'(count_hi), vecs[v].e_hi);
            check($sformatf("v%0d_mid", v), int'(count_mid), vecs[v].e_mid);
            check($sformatf("v%0d_lo", v), int'(count_lo), vecs[v].e_lo);
            check($sformatf("v%0d_ready", v), int'(req_ready), 1);
        end

        // Zero-amount request: done the cycle after acceptance, no eject
        apply_reset();
        refill(0, 5);
        req_valid  = 1'b1;
        req_amount = '0;
        tick();
        req_valid  = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_short", int'(short), 0);
        check("zero_paid", int'(paid), 0);
        check("zero_eject", int'(eject), 0);
        check("zero_busy", int'(req_ready), 0);
        tick();
        check("zero_done_pulse", int'(done), 0);
        check("zero_ready_again", int'(req_ready), 1);

        // Hopper never acks: fault exactly 16 cycles after eject
        apply_reset();
        refill(0, 1);
        req_valid  = 1'b1;
        req_amount = 8'd1;
        tick();
        req_valid  = 1'b0;
        check("to_busy", int'(req_ready), 0);
        tick();
        check("to_eject", int'(eject), 1);
        n = 0;
        for (int i = 0; i < 40 && fault == 1'b0; i++) begin
            tick();
            n++;
            if (fault == 1'b0) check("to_no_early_done", int'(done), 0);
        end
        check("to_cycles", n, 16);
        check("to_fault", int'(fault), 1);
        check("to_done", int'(done), 1);
        check("to_short", int'(short), 1);
        check("to_count_kept", int'(count_lo), 1);
        check("to_paid", int'(paid), 0);
        req_valid  = 1'b1;
        req_amount = 8'd7;
        refill_valid = 1'b1;
        refill_sel   = 2'd0;
        refill_count = 6'd2;
        tick();
        req_valid    = 1'b0;
        refill_valid = 1'b0;
        check("to_done_pulse", int'(done), 0);
        check("to_fault_sticky", int'(fault), 1);
        check("to_req_ignored", int'(remaining), 1);
        check("to_refill_in_fault", int'(count_lo), 3);
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        check("to_cleared", int'(fault), 0);
        check("to_idle", int'(req_ready), 1);

        // Ack on the very cycle the timer expires: the ack wins
        apply_reset();
        refill(0, 1);
        req_valid  = 1'b1;
        req_amount = 8'd1;
        tick();
        req_valid  = 1'b0;
        tick();
        check("race_eject", int'(eject), 1);
        repeat (15) tick();
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        check("race_no_fault", int'(fault), 0);
        check("race_paid", int'(paid), 1);
        check("race_count", int'(count_lo), 0);
        tick();
        check("race_done", int'(done), 1);
        check("race_short", int'(short), 0);
        tick();

        // Refill saturation, and refill coinciding with an ack on a full counter
        apply_reset();
        refill(0, 10);
        refill(0, 60);
        check("sat_lo", int'(count_lo), 63);
        req_valid  = 1'b1;
        req_amount = 8'd1;
        tick();
        req_valid  = 1'b0;
        tick();
        check("sat_eject", int'(eject), 1);
        tick();
        eject_ack    = 1'b1;
        refill_valid = 1'b1;
        refill_sel   = 2'd0;
        refill_count = 6'd1;
        tick();
        eject_ack    = 1'b0;
        refill_valid = 1'b0;
        check("sat_ack_refill", int'(count_lo), 63);
        check("sat_paid", int'(paid), 1);
        tick();
        check("sat_done", int'(done), 1);
        tick();

        // Reset in the middle of WAIT_ACK, then normal service
        apply_reset();
        refill(2, 3);
        req_valid  = 1'b1;
        req_amount = 8'd5;
        tick();
        req_valid  = 1'b0;
        tick();
        check("mid_eject", int'(eject), 4);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_ready", int'(req_ready), 1);
        check("mid_rst_remaining", int'(remaining), 0);
        check("mid_rst_count", int'(count_hi), 0);
        check("mid_rst_eject", int'(eject), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_done", int'(done), 0);
        end
        reset = 1'b0;
        tick();
        check("mid_after_no_done", int'(done), 0);
        refill(2, 3);
        serve(5, 1);
        check("mid_after_paid", got_paid, 5);
        check("mid_after_short", got_short, 0);
        check("mid_after_count", int'(count_hi), 2);

        // Randomized requests against the greedy model
        apply_reset();
        m_inv = '{0, 0, 0};
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(2, 0));
            for (int r = 0; r < k; r++) begin
                s = int'($urandom_range(3, 0));
                c = int'($urandom_range(25, 0));
                refill(s, c);
                if (s < 3) m_inv[s] = (m_inv[s] + c > 63) ? 63 : m_inv[s] + c;
            end
            amt = int'($urandom_range(30, 0));
            model_request(amt);
            serve(amt, 3);
            check("rnd_ncoins", got_coins.size(), exp_coins.size());
            for (int i = 0; i < exp_coins.size() && i < got_coins.size(); i++)
                check("rnd_coin", int'(got_coins[i]), int'(exp_coins[i]));
            check("rnd_paid", got_paid, m_paid);
            check("rnd_short", got_short, m_short);
            check("rnd_remaining", got_rem, m_rem);
            check("rnd_hi", int'(count_hi), m_inv[2]);
            check("rnd_mid", int'(count_mid), m_inv[1]);
            check("rnd_lo", int'(count_lo), m_inv[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
